// File: rtl/key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_sched_ctrl
// Brief    : Lockstep sequencer for the AES key-schedule shift array:
//            key load, NR round expansions, final-key flush and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module key_sched_ctrl #(
    parameter int NR         = 10,
    parameter int WORDS      = 16,
    parameter int ROT_CYCLES = 1,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       inp_ctrl,
    output logic       rotate_ctrl,
    output logic       key_in_req,
    output logic       sbox_en,
    output logic       rcon_en,
    output logic [7:0] rcon,
    output logic       rk_valid,
    output logic [3:0] rk_round,
    output logic [3:0] word_idx,
    output logic       done
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_rot    = 3'd2;
    localparam logic [2:0] c_st_expand = 3'd3;
    localparam logic [2:0] c_st_flush  = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    localparam logic [CNT_W-1:0] c_word_last = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] c_rot_last  = CNT_W'(ROT_CYCLES - 1);
    localparam logic [3:0]       c_nr        = 4'(NR);

    logic [2:0]       r_state, w_state;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [3:0]       r_round, w_round;
    logic [7:0]       r_rcon,  w_rcon;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_round <= '0;
            r_rcon  <= 8'h01;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_round <= w_round;
            r_rcon  <= w_rcon;
        end
    end

    // Outputs are decoded from registered state only, so start never reaches them.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_round     = r_round;
        w_rcon      = r_rcon;
        busy        = 1'b0;
        inp_ctrl    = 1'b0;
        rotate_ctrl = 1'b0;
        key_in_req  = 1'b0;
        sbox_en     = 1'b0;
        rcon_en     = 1'b0;
        rcon        = 8'h00;
        rk_valid    = 1'b0;
        rk_round    = 4'd0;
        word_idx    = 4'd0;
        done        = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state = c_st_load;
                    w_cnt   = '0;
                    w_round = 4'd0;
                    w_rcon  = 8'h01;
                end
            end
            c_st_load: begin
                busy       = 1'b1;
                key_in_req = 1'b1;
                word_idx   = r_cnt[3:0];
                if (r_cnt == c_word_last) begin
                    w_state = c_st_rot;
                    w_cnt   = '0;
                    w_round = 4'd1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            c_st_rot: begin
                busy        = 1'b1;
                inp_ctrl    = 1'b1;
                rotate_ctrl = 1'b1;
                if (r_cnt == c_rot_last) begin
                    w_state = c_st_expand;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            c_st_expand: begin
                busy     = 1'b1;
                inp_ctrl = 1'b1;
                rk_valid = 1'b1;
                // key_out still carries the previous round's words
                rk_round = r_round - 4'd1;
                word_idx = r_cnt[3:0];
                sbox_en  = (r_cnt < CNT_W'(2));
                if (r_cnt == '0) begin
                    rcon_en = 1'b1;
                    rcon    = r_rcon;
                end
                if (r_cnt == c_word_last) begin
                    w_cnt = '0;
                    if (r_round < c_nr) begin
                        w_state = c_st_rot;
                        w_round = r_round + 4'd1;
                        w_rcon  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
                    end else begin
                        w_state = c_st_flush;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            c_st_flush: begin
                busy     = 1'b1;
                inp_ctrl = 1'b1;
                rk_valid = 1'b1;
                rk_round = c_nr;
                word_idx = r_cnt[3:0];
                if (r_cnt == c_word_last) begin
                    w_state = c_st_done;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            c_st_done: begin
                busy    = 1'b1;
                done    = 1'b1;
                w_state = c_st_idle;
                w_cnt   = '0;
            end
            default: begin
                w_state = c_st_idle;
                w_cnt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_sched_ctrl
// Brief    : Self-checking bench for key_sched_ctrl (default and NR=2/ROT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_sched_ctrl;

    localparam int W     = 16;
    localparam int NR_A  = 10;
    localparam int ROT_A = 1;
    localparam int NR_B  = 2;
    localparam int ROT_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic       a_busy, a_inp, a_rot, a_kreq, a_sbox, a_rce, a_rkv, a_done;
    logic [7:0] a_rcon;
    logic [3:0] a_rkr, a_widx;
    logic       b_busy, b_inp, b_rot, b_kreq, b_sbox, b_rce, b_rkv, b_done;
    logic [7:0] b_rcon;
    logic [3:0] b_rkr, b_widx;

    key_sched_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(a_busy), .inp_ctrl(a_inp),
        .rotate_ctrl(a_rot), .key_in_req(a_kreq), .sbox_en(a_sbox), .rcon_en(a_rce),
        .rcon(a_rcon), .rk_valid(a_rkv), .rk_round(a_rkr), .word_idx(a_widx), .done(a_done)
    );

    key_sched_ctrl #(.NR(NR_B), .ROT_CYCLES(ROT_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(b_busy), .inp_ctrl(b_inp),
        .rotate_ctrl(b_rot), .key_in_req(b_kreq), .sbox_en(b_sbox), .rcon_en(b_rce),
        .rcon(b_rcon), .rk_valid(b_rkv), .rk_round(b_rkr), .word_idx(b_widx), .done(b_done)
    );

    wire logic [23:0] obs_a = {a_busy, a_inp, a_rot, a_kreq, a_sbox, a_rce, a_rcon,
                               a_rkv, a_rkr, a_widx, a_done};
    wire logic [23:0] obs_b = {b_busy, b_inp, b_rot, b_kreq, b_sbox, b_rce, b_rcon,
                               b_rkv, b_rkr, b_widx, b_done};

    int checks = 0;
    int errors = 0;

    function automatic logic [23:0] mk(bit busy, bit inp, bit rot, bit kreq, bit sbox,
                                       bit rce, logic [7:0] rc, bit rkv,
                                       logic [3:0] rkr, logic [3:0] wi, bit dn);
        return {busy, inp, rot, kreq, sbox, rce, rc, rkv, rkr, wi, dn};
    endfunction

    // r-th AES round constant by repeated GF(2^8) doubling
    function automatic logic [7:0] rc_of(int r);
        int x = 1;
        for (int i = 1; i < r; i++) begin
            x = x * 2;
            if (x > 255) x = x ^ 'h11B;
        end
        return 8'(x);
    endfunction

    // cycles from the first LOAD cycle through the DONE cycle
    function automatic int sched_len(int nr, int rot);
        return W + nr * (rot + W) + W + 1;
    endfunction

    // expected outputs k cycles into a schedule
    function automatic logic [23:0] rec_at(int nr, int rot, int k);
        int per, r, j, e;
        if (k < W) return mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 4'd0, 4'(k), 0);
        k -= W;
        per = rot + W;
        if (k < nr * per) begin
            r = k / per + 1;
            j = k % per;
            if (j < rot) return mk(1, 1, 1, 0, 0, 0, 8'h00, 0, 4'd0, 4'd0, 0);
            e = j - rot;
            return mk(1, 1, 0, 0, e < 2, e == 0, (e == 0) ? rc_of(r) : 8'h00,
                      1, 4'(r - 1), 4'(e), 0);
        end
        k -= nr * per;
        if (k < W) return mk(1, 1, 0, 0, 0, 0, 8'h00, 1, 4'(nr), 4'(k), 0);
        return mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 4'd0, 4'd0, 1);
    endfunction

    task automatic chk(string nm, int cyc, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", nm, cyc, got, want);
        end
    endtask

    localparam int LEN_A = sched_len(NR_A, ROT_A);
    localparam int LEN_B = sched_len(NR_B, ROT_B);

    int pos_a = -1;
    int pos_b = -1;
    int it = 0;
    bit collect = 0;
    logic [7:0] rq_a[$];
    logic [7:0] rq_b[$];
    int sbox_a = 0, sbox_b = 0, rkv_a = 0, done_cnt_a = 0;
    int done_at_a = -1, done_at_b = -1;
    int hist_a[16];

    task automatic cycle(input logic s, input logic r);
        logic [23:0] ea, eb;
        @(negedge clk);
        ea = (pos_a < 0) ? 24'h0 : rec_at(NR_A, ROT_A, pos_a);
        eb = (pos_b < 0) ? 24'h0 : rec_at(NR_B, ROT_B, pos_b);
        chk("sched_a", it, 32'(obs_a), 32'(ea));
        chk("sched_b", it, 32'(obs_b), 32'(eb));
        if (collect) begin
            if (a_rce) rq_a.push_back(a_rcon);
            if (a_sbox) sbox_a++;
            if (a_rkv) begin rkv_a++; hist_a[a_rkr]++; end
            if (a_done) begin done_cnt_a++; done_at_a = it; end
            if (it <= LEN_B) begin
                if (b_rce) rq_b.push_back(b_rcon);
                if (b_sbox) sbox_b++;
                if (b_done) done_at_b = it;
            end
        end
        start = s;
        rst   = r;
        @(posedge clk);
        if (r) begin
            pos_a = -1;
            pos_b = -1;
        end else begin
            if (pos_a < 0) begin
                if (s) pos_a = 0;
            end else begin
                pos_a++;
                if (pos_a >= LEN_A) pos_a = -1;
            end
            if (pos_b < 0) begin
                if (s) pos_b = 0;
            end else begin
                pos_b++;
                if (pos_b >= LEN_B) pos_b = -1;
            end
        end
        it++;
    endtask

    typedef struct {
        logic        rst;
        logic        start;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        for (int i = 0; i < 16; i++) hist_a[i] = 0;

        vecs[0] = '{1'b1, 1'b1, 24'h0};
        vecs[1] = '{1'b0, 1'b0, 24'h0};
        vecs[2] = '{1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 4'd0, 4'd0, 0)};
        vecs[3] = '{1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 4'd0, 4'd1, 0)};
        vecs[4] = '{1'b0, 1'b0, mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 4'd0, 4'd2, 0)};
        vecs[5] = '{1'b1, 1'b0, 24'h0};
        vecs[6] = '{1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0, 8'h00, 0, 4'd0, 4'd0, 0)};
        vecs[7] = '{1'b1, 1'b1, 24'h0};
        vecs[8] = '{1'b0, 1'b0, 24'h0};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            start = vecs[i].start;
            @(posedge clk);
            #1;
            chk("vec_a", i, 32'(obs_a), 32'(vecs[i].exp));
            chk("vec_b", i, 32'(obs_b), 32'(vecs[i].exp));
        end

        // full run with starts that must be ignored, incl. on the DONE cycle
        collect = 1;
        it = 0;
        for (int i = 0; i < LEN_A + 5; i++)
            cycle((i == 0 || i == 5 || i == 100 || i == LEN_A), 1'b0);
        collect = 0;

        chk("rcon_cnt_a", 0, rq_a.size(), NR_A);
        for (int i = 0; i < rq_a.size() && i < NR_A; i++)
            chk("rcon_a", i, 32'(rq_a[i]), 32'(rc_of(i + 1)));
        chk("sbox_cnt_a", 0, sbox_a, 2 * NR_A);
        chk("rkv_cnt_a", 0, rkv_a, (NR_A + 1) * W);
        for (int r = 0; r <= NR_A; r++) chk("rkv_group_a", r, hist_a[r], W);
        chk("done_at_a", 0, done_at_a, LEN_A);
        chk("done_cnt_a", 0, done_cnt_a, 1);
        chk("rcon_cnt_b", 0, rq_b.size(), NR_B);
        for (int i = 0; i < rq_b.size() && i < NR_B; i++)
            chk("rcon_b", i, 32'(rq_b[i]), 32'(rc_of(i + 1)));
        chk("sbox_cnt_b", 0, sbox_b, 2 * NR_B);
        chk("done_at_b", 0, done_at_b, LEN_B);

        // reset mid-expansion, then a clean restart
        it = 0;
        for (int i = 0; i < 62 + LEN_A + 5; i++)
            cycle((i == 0 || i == 62), (i == 60));

        // random start/reset traffic against the schedule model
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 700; i++)
                cycle(($urandom_range(0, 99) < 4), ($urandom_range(0, 999) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
